// File: rtl/proj_pixel_queue_pkg.sv
// Shared types and constants for the projected-vertex pixel queue.
// Holds the FSM encoding, half-float field layout and screen defaults.
package proj_pixel_queue_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        CONVX   = 3'd2,
        CONVY   = 3'd3,
        PUSH    = 3'd4
    } state_t;

    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 5;
    localparam int MAN_W    = 10;
    localparam int HALF_W   = SIGN_W + EXP_W + MAN_W;
    localparam int EXP_BIAS = 15;

    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

    localparam int PIX_X_W = 10;
    localparam int PIX_Y_W = 9;

    // Error counters stick at 255 rather than wrapping.
    function automatic logic [7:0] satAdd(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/proj_pixel_queue_if.sv
// Vertex-in / pixel-out bundle between the memory manager, the queue and the vga consumer.
interface proj_pixel_queue_if;
    import proj_pixel_queue_pkg::*;

    logic               iEnable;
    logic               iVertex;
    logic [HALF_W-1:0]  i_ieee754X;
    logic [HALF_W-1:0]  i_ieee754Y;
    logic               iReady;
    logic [PIX_X_W-1:0] oPixX;
    logic [PIX_Y_W-1:0] oPixY;
    logic               oValid;
    logic               oBusy;
    logic               oFull;
    logic [7:0]         oRangeErrCnt;
    logic [7:0]         oDropCnt;

    modport master (
        output iEnable, iVertex, i_ieee754X, i_ieee754Y, iReady,
        input  oPixX, oPixY, oValid, oBusy, oFull, oRangeErrCnt, oDropCnt
    );

    modport slave (
        input  iEnable, iVertex, i_ieee754X, i_ieee754Y, iReady,
        output oPixX, oPixY, oValid, oBusy, oFull, oRangeErrCnt, oDropCnt
    );

endinterface

// File: rtl/proj_pixel_queue_half_to_pix.sv
// Combinational half-float to screen-pixel conversion for one axis.
// invert=1 flips the sign sense so positive values move toward row 0.
module half_to_pix
    import proj_pixel_queue_pkg::*;
(
    input  logic [HALF_W-1:0]  half,
    input  logic [PIX_X_W-1:0] halfRes,
    input  logic               invert,
    output logic [PIX_X_W-1:0] pix,
    output logic               rangeErr
);

    logic [EXP_W-1:0]   e;
    logic [MAN_W-1:0]   m;
    logic [31:0]        q;
    logic [MAN_W:0]     mag;
    logic [11:0]        sum;
    logic [11:0]        maxPix;

    always_comb begin
        e = half[HALF_W-2 -: EXP_W];
        m = half[MAN_W-1:0];
        q = '0;
        // q is |v| in 1/1024 units; anything above 1.0 is off-screen
        if (e == '0)
            q = '0;
        else if (e > EXP_W'(EXP_BIAS))
            q = {21'd0, 1'b1, m} << (e - EXP_W'(EXP_BIAS));
        else
            q = {21'd0, 1'b1, m} >> (EXP_W'(EXP_BIAS) - e);

        rangeErr = (e == '1) || (q > 32'd1024);
        mag      = 11'(({10'd0, q[10:0]} * {11'd0, halfRes}) >> 10);
        maxPix   = {1'b0, halfRes, 1'b0} - 12'd1;

        if (half[HALF_W-1] ^ invert)
            sum = {2'b00, halfRes} - {1'b0, mag};
        else
            sum = {2'b00, halfRes} + {1'b0, mag};

        pix = (sum > maxPix) ? maxPix[PIX_X_W-1:0] : sum[PIX_X_W-1:0];
    end

endmodule

// File: rtl/proj_pixel_queue.sv
// Captures projected vertices, converts them to pixel coordinates and queues
// them for the vga consumer; one shared converter serves both axes.
module proj_pixel_queue
    import proj_pixel_queue_pkg::*;
#(
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES,
    parameter int DEPTH = 8
) (
    input  logic              iClock,
    input  logic              iReset,
    proj_pixel_queue_if.slave bus
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int ENT_W = PIX_X_W + PIX_Y_W;
    localparam logic [PIX_X_W-1:0] H_HALF = PIX_X_W'(H_RES / 2);
    localparam logic [PIX_X_W-1:0] V_HALF = PIX_X_W'(V_RES / 2);

    state_t             state;
    logic               vtxReg, vtxPrev, armed, strobe;
    logic [HALF_W-1:0]  xLat, yLat;
    logic [PIX_X_W-1:0] pixX;
    logic [PIX_Y_W-1:0] pixY;
    logic               rngFlag;

    logic [HALF_W-1:0]  convHalf;
    logic [PIX_X_W-1:0] convHalfRes, convPix;
    logic               convInv, convRange;

    logic [ENT_W-1:0]   mem [DEPTH];
    logic [PW-1:0]      wrPtr, rdPtr;
    logic [CW-1:0]      count;
    logic               valid, full, pop, doWrite, errInc;
    logic [1:0]         dropInc;
    logic [7:0]         rangeErrCnt, dropCnt;

    // armed stays low after reset until iVertex is seen low, so a stale high is not a strobe
    assign strobe = bus.iEnable && armed && vtxReg && !vtxPrev;

    assign convInv     = (state == CONVY);
    assign convHalf    = convInv ? yLat : xLat;
    assign convHalfRes = convInv ? V_HALF : H_HALF;

    half_to_pix uConv (
        .half     (convHalf),
        .halfRes  (convHalfRes),
        .invert   (convInv),
        .pix      (convPix),
        .rangeErr (convRange)
    );

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign pop     = valid && bus.iReady;
    assign doWrite = bus.iEnable && (state == PUSH) && !rngFlag && (!full || pop);
    assign errInc  = bus.iEnable && (state == PUSH) && rngFlag;
    assign dropInc = {1'b0, strobe && (state != IDLE)}
                   + {1'b0, bus.iEnable && (state == PUSH) && !rngFlag && full && !pop};

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state       <= IDLE;
            vtxReg      <= 1'b0;
            vtxPrev     <= 1'b0;
            armed       <= 1'b0;
            xLat        <= '0;
            yLat        <= '0;
            pixX        <= '0;
            pixY        <= '0;
            rngFlag     <= 1'b0;
            rangeErrCnt <= '0;
            dropCnt     <= '0;
        end else begin
            vtxReg      <= bus.iVertex;
            vtxPrev     <= vtxReg;
            if (!bus.iVertex) armed <= 1'b1;
            rangeErrCnt <= satAdd(rangeErrCnt, {1'b0, errInc});
            dropCnt     <= satAdd(dropCnt, dropInc);

            if (!bus.iEnable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    if (strobe) state <= CAPTURE;
                    CAPTURE: begin
                        xLat  <= bus.i_ieee754X;
                        yLat  <= bus.i_ieee754Y;
                        state <= CONVX;
                    end
                    CONVX: begin
                        pixX    <= convPix;
                        rngFlag <= convRange;
                        state   <= CONVY;
                    end
                    CONVY: begin
                        pixY    <= convPix[PIX_Y_W-1:0];
                        rngFlag <= rngFlag | convRange;
                        state   <= PUSH;
                    end
                    PUSH:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Dropping iEnable flushes the queue regardless of any concurrent pop.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (!bus.iEnable) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + 1'b1;
            if (pop)     rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(doWrite) - CW'(pop);
        end
    end

    always_ff @(posedge iClock) begin
        if (doWrite) mem[wrPtr] <= {pixX, pixY};
    end

    assign bus.oValid       = valid;
    assign bus.oFull        = full;
    assign bus.oBusy        = (state != IDLE);
    assign bus.oPixX        = valid ? mem[rdPtr][ENT_W-1:PIX_Y_W] : '0;
    assign bus.oPixY        = valid ? mem[rdPtr][PIX_Y_W-1:0] : '0;
    assign bus.oRangeErrCnt = rangeErrCnt;
    assign bus.oDropCnt     = dropCnt;

endmodule

// File: tb/tb_proj_pixel_queue.sv
// Randomized and directed bench for proj_pixel_queue against a cycle-stepped
// reference model built from the vertex/queue rules (occupancy window, queue of pixels).
module tb_proj_pixel_queue;

    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int DEPTH = 8;

    typedef struct { int x; int y; } ent_t;

    logic clk;
    logic rst;
    proj_pixel_queue_if bus();

    proj_pixel_queue #(.H_RES(H_RES), .V_RES(V_RES), .DEPTH(DEPTH)) dut (
        .iClock (clk),
        .iReset (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int testCnt = 0;
    int failCnt = 0;
    int cyc = 0;

    ent_t mq[$];
    bit   pendValid, strobePend;
    int   pendAt, latchAt, strobeAt;
    logic [15:0] pX, pY;
    int   mErr, mDrop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int expPix(input logic [15:0] h, input int res, input bit yAxis, output bit rng);
        int e, m, half, mag, p;
        longint q;
        bit toLow;
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        half = res / 2;
        if (e == 0)       q = 0;
        else if (e >= 15) q = longint'(1024 + m) * (longint'(1) << (e - 15));
        else              q = longint'((1024 + m) / (1 << (15 - e)));
        rng = (e == 31) || (q > 1024);
        mag = rng ? 0 : int'((q * half) / 1024);
        // +x moves right; +y moves up the screen, i.e. toward row 0
        toLow = yAxis ? !h[15] : h[15];
        p = toLow ? half - mag : half + mag;
        if (p > res - 1) p = res - 1;
        return p;
    endfunction

    function automatic logic [15:0] rndHalf();
        logic [4:0] e;
        case ($urandom % 10)
            0:       e = 5'd31;
            1:       e = 5'd16;
            default: e = 5'($urandom_range(0, 15));
        endcase
        return {1'($urandom % 2), e, 10'($urandom)};
    endfunction

    function automatic logic [15:0] rndOk();
        return {1'($urandom % 2), 5'($urandom_range(0, 14)), 10'($urandom)};
    endfunction

    task automatic clearModel();
        mq.delete();
        pendValid  = 0;
        strobePend = 0;
        mErr       = 0;
        mDrop      = 0;
    endtask

    task automatic checkAll();
        chk("valid", 32'(bus.oValid), 32'(mq.size() != 0));
        chk("full",  32'(bus.oFull),  32'(mq.size() == DEPTH));
        chk("busy",  32'(bus.oBusy),  32'(pendValid));
        if (mq.size() != 0) begin
            chk("pixX", 32'(bus.oPixX), 32'(mq[0].x));
            chk("pixY", 32'(bus.oPixY), 32'(mq[0].y));
        end else begin
            chk("pixX0", 32'(bus.oPixX), 32'd0);
            chk("pixY0", 32'(bus.oPixY), 32'd0);
        end
        chk("rngCnt",  32'(bus.oRangeErrCnt), 32'(mErr));
        chk("dropCnt", 32'(bus.oDropCnt),     32'(mDrop));
    endtask

    task automatic chkZero(input string tag);
        chk({tag, "_valid"}, 32'(bus.oValid), 32'd0);
        chk({tag, "_full"},  32'(bus.oFull),  32'd0);
        chk({tag, "_busy"},  32'(bus.oBusy),  32'd0);
        chk({tag, "_x"},     32'(bus.oPixX),  32'd0);
        chk({tag, "_y"},     32'(bus.oPixY),  32'd0);
        chk({tag, "_rng"},   32'(bus.oRangeErrCnt), 32'd0);
        chk({tag, "_drop"},  32'(bus.oDropCnt), 32'd0);
    endtask

    // Model advances using the inputs present before the edge, then the DUT is compared.
    task automatic tick();
        bit pop, doPush, rx, ry;
        int ex, ey;
        doPush = 0;
        if (rst) begin
            clearModel();
        end else if (!bus.iEnable) begin
            if (strobePend && strobeAt == cyc + 1) strobePend = 0;
            mq.delete();
            pendValid = 0;
        end else begin
            pop = (mq.size() > 0) && bus.iReady;
            if (strobePend && strobeAt == cyc + 1) begin
                strobePend = 0;
                if (pendValid) begin
                    if (mDrop < 255) mDrop++;
                end else begin
                    pendValid = 1;
                    latchAt   = cyc + 2;
                    pendAt    = cyc + 5;
                end
            end
            if (pendValid && latchAt == cyc + 1) begin
                pX = bus.i_ieee754X;
                pY = bus.i_ieee754Y;
            end
            if (pendValid && pendAt == cyc + 1) begin
                pendValid = 0;
                ex = expPix(pX, H_RES, 1'b0, rx);
                ey = expPix(pY, V_RES, 1'b1, ry);
                if (rx || ry) begin
                    if (mErr < 255) mErr++;
                end else if (mq.size() < DEPTH || pop) begin
                    doPush = 1;
                end else if (mDrop < 255) begin
                    mDrop++;
                end
            end
            if (pop) void'(mq.pop_front());
            if (doPush) mq.push_back('{x: ex, y: ey});
        end
        @(posedge clk);
        cyc++;
        #1;
        checkAll();
    endtask

    task automatic vertex(input logic [15:0] x, input logic [15:0] y);
        bus.i_ieee754X = x;
        bus.i_ieee754Y = y;
        bus.iVertex    = 1'b1;
        strobePend     = 1;
        strobeAt       = cyc + 2;
        tick();
        bus.iVertex    = 1'b0;
    endtask

    task automatic doReset(input bit staleVtx);
        rst = 1'b1;
        bus.iVertex = staleVtx;
        clearModel();
        #1;
        chkZero("rst");
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic dirPair(input logic [15:0] x, input logic [15:0] y, input int ex, input int ey);
        bus.iReady = 1'b0;
        vertex(x, y);
        repeat (6) tick();
        chk("dirX", 32'(bus.oPixX), 32'(ex));
        chk("dirY", 32'(bus.oPixY), 32'(ey));
        bus.iReady = 1'b1;
        tick();
        bus.iReady = 1'b0;
        tick();
    endtask

    initial begin
        int base;
        clk = 1'b0;
        bus.iEnable    = 1'b1;
        bus.iVertex    = 1'b0;
        bus.i_ieee754X = '0;
        bus.i_ieee754Y = '0;
        bus.iReady     = 1'b0;
        clearModel();
        doReset(1'b0);

        // centre point and push latency
        bus.iReady = 1'b1;
        vertex(16'h0000, 16'h0000);
        repeat (4) tick();
        chk("lat4", 32'(bus.oValid), 32'd0);
        tick();
        chk("lat5", 32'(bus.oValid), 32'd1);
        chk("ctrX", 32'(bus.oPixX), 32'd320);
        chk("ctrY", 32'(bus.oPixY), 32'd240);
        tick();

        dirPair(16'h3C00, 16'h3C00, 639, 0);
        dirPair(16'hBC00, 16'hBC00, 0, 479);
        dirPair(16'h3800, 16'hB800, 480, 360);

        // out-of-range vertices: one count per vertex, never pushed
        base = mErr;
        vertex(16'h3C01, 16'h0000);
        repeat (7) tick();
        chk("rngX", 32'(bus.oRangeErrCnt), 32'(base + 1));
        chk("rngXv", 32'(bus.oValid), 32'd0);
        vertex(16'h0000, 16'h7E00);
        repeat (7) tick();
        chk("rngY", 32'(bus.oRangeErrCnt), 32'(base + 2));
        vertex(16'h7C00, 16'h7E00);
        repeat (7) tick();
        chk("rngXY", 32'(bus.oRangeErrCnt), 32'(base + 3));

        // overflow then in-order drain
        doReset(1'b0);
        bus.iReady = 1'b0;
        repeat (9) begin
            vertex(rndOk(), rndOk());
            repeat (6) tick();
        end
        chk("fullF", 32'(bus.oFull), 32'd1);
        chk("fullD", 32'(bus.oDropCnt), 32'd1);
        bus.iReady = 1'b1;
        repeat (10) tick();
        chk("drained", 32'(bus.oValid), 32'd0);

        // strobe while converting X
        base = mDrop;
        vertex(16'h3400, 16'h3400);
        tick();
        vertex(16'hB400, 16'hB400);
        repeat (7) tick();
        chk("dropConv", 32'(bus.oDropCnt), 32'(base + 1));

        // enable low during CONVY with one entry already queued
        bus.iReady = 1'b0;
        vertex(16'h3000, 16'h3000);
        repeat (6) tick();
        vertex(16'h3800, 16'h3800);
        repeat (3) tick();
        bus.iEnable = 1'b0;
        tick();
        bus.iEnable = 1'b1;
        repeat (6) tick();
        chk("flushV", 32'(bus.oValid), 32'd0);
        chk("flushB", 32'(bus.oBusy), 32'd0);

        // asynchronous reset mid-operation
        vertex(16'h3000, 16'h3000);
        repeat (6) tick();
        vertex(16'h3800, 16'h3800);
        repeat (2) tick();
        rst = 1'b1;
        clearModel();
        #1;
        chkZero("midRst");
        tick();
        rst = 1'b0;
        tick();

        // stale iVertex high across reset must not strobe
        doReset(1'b1);
        repeat (6) tick();
        chk("staleB", 32'(bus.oBusy), 32'd0);
        bus.iVertex = 1'b0;
        tick();
        tick();
        vertex(16'h3800, 16'h3800);
        repeat (6) tick();
        chk("staleOk", 32'(bus.oValid), 32'd1);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            if ($urandom % 16 == 0) begin
                bus.iEnable = 1'b0;
                tick();
                bus.iEnable = 1'b1;
            end
            vertex(rndHalf(), rndHalf());
            repeat ($urandom_range(1, 8)) begin
                bus.iReady = 1'($urandom % 2);
                tick();
            end
        end
        bus.iReady = 1'b1;
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/proj_pixel_queue.md
PROJ_PIXEL_QUEUE -- requirements
Module: proj_pixel_queue

Interface
REQ-001 Parameter H_RES, default 640, horizontal screen resolution in pixels.
REQ-002 Parameter V_RES, default 480, vertical screen resolution in pixels.
REQ-003 Parameter DEPTH, default 8, number of FIFO entries, power of two.
REQ-004 iClock  input  1  single clock; all state on rising edge.
REQ-005 iReset  input  1  asynchronous, active-high reset.
REQ-006 iEnable  input  1  memory-manager enable; low means flush.
REQ-007 iVertex  input  1  vertex strobe; a rising edge means X/Y are valid.
REQ-008 i_ieee754X, i_ieee754Y  input  16 each  projected coordinates, IEEE-754 half precision.
REQ-009 oPixX  output  10  pixel column at FIFO head.
REQ-010 oPixY  output  9  pixel row at FIFO head.
REQ-011 oValid  output  1  FIFO non-empty.
REQ-012 iReady  input  1  consumer (vga) accepts the head entry.
REQ-013 oBusy  output  1  FSM not in IDLE.
REQ-014 oFull  output  1  FIFO holds DEPTH entries.
REQ-015 oRangeErrCnt, oDropCnt  output  8 each  saturating error counters.

Function
REQ-016 Strobe detection: iVertex is registered once; a strobe is iVertex=1 with the previous sample 0 while iEnable=1.
REQ-017 FSM states: IDLE, CAPTURE, CONVX, CONVY, PUSH.
REQ-018 Transitions: IDLE->CAPTURE on strobe; CAPTURE latches X/Y; CAPTURE->CONVX->CONVY->PUSH, one cycle each; PUSH->IDLE.
REQ-019 A strobe seen in any state other than IDLE is discarded and increments oDropCnt.
REQ-020 Conversion of a half value h (sign s, exponent e, mantissa m): e=0 gives magnitude 0; otherwise Q=(1024+m) shifted left by (e-15) when e>15 and right by (15-e) when e<15, giving |v| in 1/1024 units.
REQ-021 Range: e=31 (Inf/NaN) or Q>1024 sets a range flag; a flagged vertex is not pushed and increments oRangeErrCnt once, even when both axes are flagged.
REQ-022 Horizontal: mag=floor(Q*(H_RES/2)/1024); pix = H_RES/2+mag for s=0 and H_RES/2-mag for s=1; clamp to H_RES-1.
REQ-023 Vertical (screen y down): mag=floor(Q*(V_RES/2)/1024); pix = V_RES/2-mag for s=0 and V_RES/2+mag for s=1; clamp to V_RES-1.
REQ-024 PUSH writes {X,Y} when the FIFO is not full or a pop occurs in the same cycle; otherwise the vertex is discarded and oDropCnt increments.
REQ-025 Pop occurs when oValid=1 and iReady=1; oPixX/oPixY always show the head entry, and show 0 when empty.
REQ-026 A simultaneous push and pop keeps the count unchanged; pointers wrap modulo DEPTH.
REQ-027 Latency: a strobe on cycle N with the FIFO empty gives oValid=1 on cycle N+5 (sync, CAPTURE, CONVX, CONVY, PUSH).
REQ-028 iEnable=0 for any cycle empties the FIFO, returns the FSM to IDLE and discards the in-flight vertex; the counters are kept.
REQ-029 Counters saturate at 255.

Reset
REQ-030 iReset asserted asynchronously forces: FSM=IDLE, FIFO empty with pointers 0, oValid=0, oFull=0, oBusy=0, oPixX=0, oPixY=0, both counters 0, strobe history 0.
REQ-031 After iReset deasserts, a stale high on iVertex does not produce a strobe until iVertex first goes low.

Structure
REQ-032 Shared package: FSM state encoding, the half-float field widths (1/5/10), the exponent bias 15, and the default H_RES/V_RES.
REQ-033 One sub-module, half_to_pix, converts a single axis combinationally; it takes half, half-resolution and invert-sign inputs, returns pixel and range flag, and is time-shared between CONVX and CONVY.
REQ-034 FIFO storage is a register array of DEPTH x 19 bits inside proj_pixel_queue.

Verification
REQ-035 X=0x0000, Y=0x0000, iReady=1 -> (320,240), oValid on cycle N+5.
REQ-036 X=0x3C00 (+1.0), Y=0x3C00 -> (639,0); X=0xBC00, Y=0xBC00 -> (0,479).
REQ-037 X=0x3800 (0.5), Y=0xB800 (-0.5) -> (480,360).
REQ-038 X=0x3C01, or Y=0x7E00 (NaN) -> no push, oRangeErrCnt=1.
REQ-039 iReady=0 and 9 spaced valid strobes -> 8 entries, oFull=1, oDropCnt=1; then iReady=1 drains them in FIFO order.
REQ-040 Strobe during CONVX -> oDropCnt+1; iEnable=0 mid-CONVY -> FIFO empty, no push; iReset mid-operation -> all outputs 0 immediately.
